// File: rtl/seq_detector_param.sv
// Programmable serial pattern detector with KMP-style prefix tracking,
// optional overlap, optional registered match and saturating match counter.
module seq_detector_param #(
  parameter int                 MAX_LEN = 8,
  parameter int                 OVERLAP = 1,
  parameter int                 REG_OUT = 1,
  parameter int                 CNT_W   = 8,
  parameter logic [MAX_LEN-1:0] RST_PAT = MAX_LEN'(8'h06),
  parameter int                 RST_LEN = 4,
  localparam int                LW      = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               din_valid,
  input  logic               din,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LW-1:0]      cfg_len,
  input  logic               cnt_clear,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic [LW-1:0]      state_o
);

  logic [MAX_LEN-1:0] pat;
  logic [LW-1:0]      len;
  logic [LW-1:0]      state;
  logic [MAX_LEN-2:0] hist;
  logic [CNT_W-1:0]   cnt;
  logic               match_q;

  logic [MAX_LEN-1:0] palign;
  logic [MAX_LEN-1:0] win;
  logic [MAX_LEN-1:0] mask;
  logic [LW-1:0]      j_sel;
  logic [LW-1:0]      border;
  logic [LW-1:0]      len_in;
  logic               hit;

  // Prefix-aligned pattern: first bit at MSB, ignored bits shifted out
  always_comb begin
    palign = pat << (MAX_LEN - int'(len));
    win    = {hist, din};
    j_sel  = '0;
    border = '0;
    mask   = '0;
    for (int j = 1; j <= MAX_LEN; j++) begin
      mask = ~({MAX_LEN{1'b1}} << j);
      if (j <= int'(state) + 1 && j <= int'(len) &&
          ((palign >> (MAX_LEN - j)) & mask) == (win & mask))
        j_sel = LW'(j);
    end
    for (int b = 1; b < MAX_LEN; b++) begin
      mask = ~({MAX_LEN{1'b1}} << b);
      if (b < int'(len) &&
          ((palign >> (MAX_LEN - b)) & mask) == (pat & mask))
        border = LW'(b);
    end
  end

  // Match event, length clamp on configuration
  always_comb begin
    hit    = din_valid && !cfg_load && (len != '0) && (j_sel == len);
    len_in = (int'(cfg_len) > MAX_LEN) ? LW'(MAX_LEN) : cfg_len;
  end

  // Configuration, matcher state, bit history, counter and registered match
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat     <= RST_PAT;
      len     <= LW'(RST_LEN);
      state   <= '0;
      hist    <= '0;
      cnt     <= '0;
      match_q <= 1'b0;
    end else begin
      match_q <= hit;
      if (cfg_load) begin
        pat   <= cfg_pattern;
        len   <= len_in;
        state <= '0;
      end else if (din_valid && len != '0) begin
        hist <= win[MAX_LEN-2:0];
        if (hit)
          state <= (OVERLAP != 0) ? border : '0;
        else
          state <= j_sel;
      end
      if (cfg_load || cnt_clear)
        cnt <= '0;
      else if (hit && cnt != '1)
        cnt <= cnt + 1'b1;
    end
  end

  assign match       = (REG_OUT != 0) ? match_q : hit;
  assign match_count = cnt;
  assign state_o     = state;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: four parameter variants share
// one stimulus stream; each scenario checks the relevant variant.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       din_valid;
  logic       din;
  logic       cfg_load;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cnt_clear;

  logic       m_a, m_b, m_c, m_d;
  logic [7:0] c_a, c_b, c_c;
  logic [1:0] c_d;
  logic [3:0] s_a, s_b, s_c, s_d;

  int tests = 0;
  int fails = 0;
  logic mealy_c;

  always #5 clk = ~clk;

  seq_detector_param u_a (
    .clk(clk), .reset(reset), .din_valid(din_valid), .din(din),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cnt_clear(cnt_clear), .match(m_a), .match_count(c_a), .state_o(s_a)
  );

  seq_detector_param #(.OVERLAP(0)) u_b (
    .clk(clk), .reset(reset), .din_valid(din_valid), .din(din),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cnt_clear(cnt_clear), .match(m_b), .match_count(c_b), .state_o(s_b)
  );

  seq_detector_param #(.REG_OUT(0)) u_c (
    .clk(clk), .reset(reset), .din_valid(din_valid), .din(din),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cnt_clear(cnt_clear), .match(m_c), .match_count(c_c), .state_o(s_c)
  );

  seq_detector_param #(.CNT_W(2)) u_d (
    .clk(clk), .reset(reset), .din_valid(din_valid), .din(din),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cnt_clear(cnt_clear), .match(m_d), .match_count(c_d), .state_o(s_d)
  );

  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One cycle: drive at negedge, sample Mealy before the edge,
  // registered outputs 1ns after it; one-shot controls then drop
  task automatic push(input logic b, input logic v);
    @(negedge clk);
    din       = b;
    din_valid = v;
    #1 mealy_c = m_c;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    cfg_load  = 1'b0;
    cnt_clear = 1'b0;
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l);
    cfg_load    = 1'b1;
    cfg_pattern = p;
    cfg_len     = l;
    push(1'b0, 1'b0);
  endtask

  logic [6:0]  s1    = 7'b0110110;
  logic [6:0]  e1a   = 7'b0001001;
  logic [6:0]  e1b   = 7'b0001000;
  logic [4:0]  s3    = 5'b10101;
  logic [4:0]  e3    = 5'b00101;
  logic [3:0]  p0110 = 4'b0110;
  logic [7:0]  pa5   = 8'hA5;

  initial begin
    reset = 1'b0; din_valid = 1'b0; din = 1'b0;
    cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0; cnt_clear = 1'b0;
    #12;
    chk("rst_match", m_a, 0);
    chk("rst_count", c_a, 0);
    chk("rst_state", s_a, 0);
    @(negedge clk);
    reset = 1'b1;

    // overlap vs non-overlap on 0110110
    for (int i = 6; i >= 0; i--) begin
      push(s1[i], 1'b1);
      chk($sformatf("ov_match_b%0d", 7 - i), m_a, int'(e1a[i]));
      chk($sformatf("nov_match_b%0d", 7 - i), m_b, int'(e1b[i]));
      if (i == 3) chk("nov_state_after", s_b, 0);
    end
    chk("ov_count", c_a, 2);
    chk("nov_count", c_b, 1);
    chk("ov_state_end", s_a, 1);

    // Mealy output on pattern 101
    load(8'h05, 4'd3);
    chk("load_clr_count", c_a, 0);
    for (int i = 4; i >= 0; i--) begin
      push(s3[i], 1'b1);
      chk($sformatf("mealy_b%0d", 5 - i), mealy_c, int'(e3[i]));
    end
    chk("mealy_count", c_c, 2);
    chk("nov101_count", c_b, 1);

    // valid gaps hold state
    load(8'h06, 4'd4);
    push(1'b0, 1'b1);
    for (int g = 0; g < 3; g++) begin
      push(1'b1, 1'b0);
      chk($sformatf("gap_state%0d", g), s_a, 1);
      chk($sformatf("gap_match%0d", g), m_a, 0);
    end
    push(1'b1, 1'b1);
    push(1'b1, 1'b1);
    push(1'b1, 1'b0);
    chk("gap_state3", s_a, 3);
    push(1'b0, 1'b1);
    chk("gap_match_end", m_a, 1);
    chk("gap_count", c_a, 1);

    // counter saturation and clear-wins
    cnt_clear = 1'b1;
    push(1'b0, 1'b0);
    chk("clr_count", c_d, 0);
    for (int r = 0; r < 5; r++)
      for (int i = 3; i >= 0; i--) push(p0110[i], 1'b1);
    chk("sat_count", c_d, 3);
    chk("wide_count", c_a, 5);
    push(1'b1, 1'b1);
    push(1'b1, 1'b1);
    cnt_clear = 1'b1;
    push(1'b0, 1'b1);
    chk("clr_evt_match", m_a, 1);
    chk("clr_evt_count_a", c_a, 0);
    chk("clr_evt_count_d", c_d, 0);

    // reload mid-prefix, bit in load cycle discarded
    push(1'b0, 1'b1);
    push(1'b1, 1'b1);
    push(1'b1, 1'b1);
    chk("pre_load_state", s_a, 3);
    cfg_load = 1'b1; cfg_pattern = 8'hA5; cfg_len = 4'd8;
    push(1'b0, 1'b1);
    chk("load_state", s_a, 0);
    chk("load_nomatch", m_a, 0);
    chk("load_nomealy", mealy_c, 0);
    for (int i = 7; i >= 0; i--) push(pa5[i], 1'b1);
    chk("a5_match", m_a, 1);
    chk("a5_count", c_a, 1);

    // zero length: idle
    load(8'h06, 4'd0);
    for (int r = 0; r < 2; r++)
      for (int i = 3; i >= 0; i--) push(p0110[i], 1'b1);
    chk("len0_count", c_a, 0);
    chk("len0_state", s_a, 0);

    // oversize length clamps to 8
    load(8'hA5, 4'd12);
    for (int i = 7; i >= 0; i--) push(pa5[i], 1'b1);
    chk("clamp_count", c_a, 1);

    // async reset right after an event
    load(8'h06, 4'd4);
    for (int i = 3; i >= 0; i--) push(p0110[i], 1'b1);
    chk("pre_rst_match", m_a, 1);
    chk("pre_rst_count", c_a, 1);
    #1 reset = 1'b0;
    #1;
    chk("arst_match", m_a, 0);
    chk("arst_count", c_a, 0);
    chk("arst_state", s_a, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 3; i >= 0; i--) push(p0110[i], 1'b1);
    chk("post_rst_pat", m_a, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
